// File: rtl/dds_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dds_ctrl_pkg
// Shared definitions for the DDS frequency-sweep controller:
//   - FSM state encoding (IDLE=0, DWELL=1, STEP=2, DONE=3)
//   - waveform select codes driven on wave_sel
//   - default frequency-word and dwell-counter widths
// -----------------------------------------------------------------------------
package dds_ctrl_pkg;

   // Default widths for the frequency (phase-increment) word and dwell counter.
   localparam int unsigned DefaultFw = 32;
   localparam int unsigned DefaultCw = 16;

   // Sweep controller states.
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StDwell = 2'd1,
      StStep  = 2'd2,
      StDone  = 2'd3
   } state_e;

   // Waveform select codes for the waveform ROM mux.
   typedef enum logic [1:0] {
      WaveSine     = 2'd0,
      WaveSquare   = 2'd1,
      WaveTriangle = 2'd2,
      WaveSawtooth = 2'd3
   } wave_e;

endpackage : dds_ctrl_pkg

// File: rtl/dds_sweep_ctrl_if.sv
// -----------------------------------------------------------------------------
// dds_sweep_ctrl_if
// Bundles the configuration handshake, abort and DDS-side outputs of the sweep
// controller.
//   master : configuration source (drives cfg_*, abort; observes status/outputs)
//   slave  : sweep controller (accepts cfg_*, abort; drives cfg_ready, freq_word,
//            wave_sel, dds_en, busy, done)
// Parameters:
//   FW : frequency word width
//   CW : dwell counter width
// -----------------------------------------------------------------------------
interface dds_sweep_ctrl_if
   import dds_ctrl_pkg::*;
#(
   parameter int unsigned FW = DefaultFw,
   parameter int unsigned CW = DefaultCw
) ();

   // Configuration handshake
   logic          cfg_valid;
   logic          cfg_ready;
   logic [FW-1:0] cfg_f_start;
   logic [FW-1:0] cfg_f_stop;
   logic [FW-1:0] cfg_f_step;
   logic [CW-1:0] cfg_dwell;
   logic [1:0]    cfg_wave;
   logic          cfg_loop;

   // Control
   logic          abort;

   // DDS-side outputs and status
   logic [FW-1:0] freq_word;
   logic [1:0]    wave_sel;
   logic          dds_en;
   logic          busy;
   logic          done;

   modport master (
      output cfg_valid, cfg_f_start, cfg_f_stop, cfg_f_step, cfg_dwell, cfg_wave,
             cfg_loop, abort,
      input  cfg_ready, freq_word, wave_sel, dds_en, busy, done
   );

   modport slave (
      input  cfg_valid, cfg_f_start, cfg_f_stop, cfg_f_step, cfg_dwell, cfg_wave,
             cfg_loop, abort,
      output cfg_ready, freq_word, wave_sel, dds_en, busy, done
   );

endinterface : dds_sweep_ctrl_if

// File: rtl/dds_dwell_cnt.sv
// -----------------------------------------------------------------------------
// dds_dwell_cnt
// Down-counter that times how long each frequency word is held.
// Ports:
//   clk        : system clock
//   rst        : synchronous active-high reset (clears the count)
//   load_i     : load load_val_i into the counter (has priority over dec_i)
//   load_val_i : value to load
//   dec_i      : decrement by one (stops at zero)
//   term_o     : count currently equals 1 (last dwell cycle)
// -----------------------------------------------------------------------------
module dds_dwell_cnt
   import dds_ctrl_pkg::*;
#(
   parameter int unsigned CW = DefaultCw
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_i,
   input  logic [CW-1:0] load_val_i,
   input  logic          dec_i,
   output logic          term_o
);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - CW'(1);
      end
   end

   assign term_o = (cnt_q == CW'(1));

endmodule : dds_dwell_cnt

// File: rtl/dds_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// dds_sweep_ctrl
// Steps a DDS frequency word from f_start towards f_stop in increments of
// f_step, holding each word for max(dwell,1)+1 cycles, optionally looping.
// Ports:
//   clk : system clock (rising edge)
//   rst : synchronous active-high reset
//   bus : dds_sweep_ctrl_if.slave
//         cfg_valid/cfg_ready handshake with cfg_f_start, cfg_f_stop,
//         cfg_f_step, cfg_dwell, cfg_wave, cfg_loop; abort;
//         outputs freq_word, wave_sel, dds_en, busy, done (all registered)
// -----------------------------------------------------------------------------
module dds_sweep_ctrl
   import dds_ctrl_pkg::*;
#(
   parameter int unsigned FW = DefaultFw,
   parameter int unsigned CW = DefaultCw
) (
   input  logic             clk,
   input  logic             rst,
   dds_sweep_ctrl_if.slave  bus
);

   // State and registered outputs
   state_e        state_q;
   logic [FW-1:0] freq_word_q;
   wave_e         wave_sel_q;
   logic          dds_en_q;
   logic          busy_q;
   logic          done_q;

   // Captured configuration
   logic [FW-1:0] f_start_q;
   logic [FW-1:0] f_stop_q;
   logic [FW-1:0] f_step_q;
   logic [CW-1:0] dwell_q;    // already clamped to at least 1
   logic          loop_q;

   // Combinational helpers
   logic          cfg_ready;
   logic          accept;
   logic [CW-1:0] cfg_dwell_eff;
   logic [FW:0]   next_sum;
   logic          sweep_end;
   logic          cnt_load;
   logic [CW-1:0] cnt_load_val;
   logic          cnt_dec;
   logic          cnt_term;

   // Ready is decoded from the state register; it is also held low while rst is
   // asserted so a configuration is never seen as offered during reset.
   assign cfg_ready     = (state_q == StIdle) && !rst;
   assign accept        = bus.cfg_valid && cfg_ready;
   assign cfg_dwell_eff = (bus.cfg_dwell == '0) ? CW'(1) : bus.cfg_dwell;

   // Next word is formed one bit wider so a wrap past 2^FW is seen as the end.
   assign next_sum  = {1'b0, freq_word_q} + {1'b0, f_step_q};
   assign sweep_end = (f_step_q == '0) || next_sum[FW] || (next_sum[FW-1:0] > f_stop_q);

   // Dwell counter control
   always_comb begin
      cnt_load     = 1'b0;
      cnt_load_val = dwell_q;
      cnt_dec      = 1'b0;
      case (state_q)
         StIdle: begin
            if (accept) begin
               cnt_load     = 1'b1;
               cnt_load_val = cfg_dwell_eff;
            end
         end
         StDwell: cnt_dec = !bus.abort;
         StStep:  cnt_load = !bus.abort && (!sweep_end || loop_q);
         StDone:  ;
         default: ;
      endcase
   end

   dds_dwell_cnt #(
      .CW (CW)
   ) u_dwell_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (cnt_load),
      .load_val_i (cnt_load_val),
      .dec_i      (cnt_dec),
      .term_o     (cnt_term)
   );

   // Sweep FSM with registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         freq_word_q <= '0;
         wave_sel_q  <= WaveSine;
         dds_en_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         f_start_q   <= '0;
         f_stop_q    <= '0;
         f_step_q    <= '0;
         dwell_q     <= '0;
         loop_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (bus.abort && (state_q != StIdle)) begin
            // Abort wins over every other transition; words are left as-is.
            state_q  <= StIdle;
            dds_en_q <= 1'b0;
            busy_q   <= 1'b0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (accept) begin
                     f_start_q   <= bus.cfg_f_start;
                     f_stop_q    <= bus.cfg_f_stop;
                     f_step_q    <= bus.cfg_f_step;
                     dwell_q     <= cfg_dwell_eff;
                     loop_q      <= bus.cfg_loop;
                     freq_word_q <= bus.cfg_f_start;
                     wave_sel_q  <= wave_e'(bus.cfg_wave);
                     dds_en_q    <= 1'b1;
                     busy_q      <= 1'b1;
                     state_q     <= StDwell;
                  end
               end
               StDwell: begin
                  if (cnt_term) begin
                     state_q <= StStep;
                  end
               end
               StStep: begin
                  if (sweep_end) begin
                     if (loop_q) begin
                        freq_word_q <= f_start_q;
                        state_q     <= StDwell;
                     end else begin
                        dds_en_q <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= StDone;
                     end
                  end else begin
                     freq_word_q <= next_sum[FW-1:0];
                     state_q     <= StDwell;
                  end
               end
               StDone: begin
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end
            endcase
         end
      end
   end

   assign bus.cfg_ready = cfg_ready;
   assign bus.freq_word = freq_word_q;
   assign bus.wave_sel  = wave_sel_q;
   assign bus.dds_en    = dds_en_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule : dds_sweep_ctrl
